// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the instruction fetch queue.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_e;

  localparam int PC_INCR = 4;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Memory request/response, redirect and core-delivery signals of the fetch front-end.
interface instr_fetch_queue_if #(
  parameter int ADDR_W = 32
);
  import fetch_pkg::*;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               if_fault;

  // The fetch unit is the master; memory and core together form the slave side.
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is read combinationally from the storage array.
module fetch_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i & (count_q != '0);

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are live.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && !do_pop && count_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front-end: owns the PC, issues credit-limited requests, queues {pc, instr} for the core.
// Define ALIGN_CHECK_EN to fault and halt on misaligned redirects instead of masking pc[1:0].
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter  int                ADDR_W   = 32,
  parameter  int                DEPTH    = 4,
  parameter  logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int                CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_queue_if.master bus,
  output logic [CNT_W-1:0]    dbg_count_o
);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, redirect_tgt, rsp_pc;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d, discard_q, discard_d;
  logic [CNT_W-1:0]  q_count, trk_count;
  logic              req_fire, rsp_keep, pop, credit_ok;
  entry_t            head, push_entry;

  assign req_fire  = bus.imem_req_valid & bus.imem_req_ready;
  assign rsp_keep  = bus.imem_rsp_valid & ~bus.redirect_valid & (discard_q == '0);
  assign pop       = bus.if_valid & bus.if_ready;
  assign credit_ok = (int'(outstanding_q) + int'(q_count)) < DEPTH;

`ifdef ALIGN_CHECK_EN
  logic misaligned;
  logic fault_q;
  assign misaligned   = bus.redirect_pc[1:0] != 2'b00;
  assign redirect_tgt = bus.redirect_pc;
  assign bus.if_fault = fault_q;
`else
  assign redirect_tgt = bus.redirect_pc & ~ADDR_W'(3);
  assign bus.if_fault = 1'b0;
`endif

  // Requests accepted in a redirect cycle are counted as outstanding and therefore discarded.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned and no latch is inferred.
    fetch_pc_d    = fetch_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
    if (bus.redirect_valid)  fetch_pc_d = redirect_tgt;
    else if (req_fire)       fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INCR);
    if (bus.redirect_valid)  discard_d = outstanding_d;
    else if (bus.imem_rsp_valid && discard_q != '0) discard_d = discard_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
`ifdef ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      if (state_q == BOOT) state_q <= RUN;
`ifdef ALIGN_CHECK_EN
      if (bus.redirect_valid) begin
        state_q <= misaligned ? HALT : RUN;
        fault_q <= misaligned;
      end
`endif
    end
  end

  // Tracks the PC of every live in-flight request; discarded requests are flushed out of it.
  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pc_trk (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (req_fire & ~bus.redirect_valid),
    .push_data_i(fetch_pc_q),
    .pop_i      (rsp_keep),
    .flush_i    (bus.redirect_valid),
    .count_o    (trk_count),
    .head_o     (rsp_pc)
  );

  assign push_entry = '{pc: rsp_pc, instr: bus.imem_rsp_data};

  fetch_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_data_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (rsp_keep),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .flush_i    (bus.redirect_valid),
    .count_o    (q_count),
    .head_o     (head)
  );

  assign bus.imem_req_valid = (state_q == RUN) && credit_ok;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.if_valid       = (q_count != '0);
  assign bus.if_pc          = bus.if_valid ? head.pc : '0;
  assign bus.if_instr       = bus.if_valid ? head.instr : '0;
  assign dbg_count_o        = q_count;

  a_credit_balance: assert property (@(posedge clk) disable iff (!rst_n)
    int'(outstanding_q) == int'(trk_count) + int'(discard_q));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: streaming, back-pressure, redirects, PC wrap, alignment.
module tb_instr_fetch_queue;
  import fetch_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_queue_if #(.ADDR_W(ADDR_W)) bus ();
  instr_fetch_queue_if #(.ADDR_W(ADDR_W)) bus2 ();
  logic [CNT_W-1:0] dbg_count, dbg_count2;

  instr_fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_count_o(dbg_count)
  );

  instr_fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .dbg_count_o(dbg_count2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ NOP_INSTR;
  endfunction

  // Memory model for the main instance: always ready, fixed latency, in-order responses.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] req_log[$];
  int          cyc = 0;
  int          lat = 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      req_log.delete();
      cyc = 0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.imem_req_ready = 1'b1;
    end else begin
      cyc++;
      bus.imem_rsp_valid = 1'b0;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = instr_of(pend[0].addr);
        void'(pend.pop_front());
      end
      bus.imem_req_ready = 1'b1;
      if (bus.imem_req_valid === 1'b1) begin
        pend.push_back('{bus.imem_req_addr, cyc + lat});
        req_log.push_back(bus.imem_req_addr);
      end
    end
  end

  // Latency-1 memory and always-ready core for the wrap-around instance.
  logic [31:0] req_log2[$];
  logic        fired2;
  logic [31:0] addr2_prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      req_log2.delete();
      fired2 = 1'b0;
      addr2_prev = '0;
      bus2.imem_rsp_valid = 1'b0;
      bus2.imem_rsp_data  = '0;
      bus2.imem_req_ready = 1'b1;
      bus2.if_ready       = 1'b1;
      bus2.redirect_valid = 1'b0;
      bus2.redirect_pc    = '0;
    end else begin
      bus2.imem_rsp_valid = fired2;
      bus2.imem_rsp_data  = instr_of(addr2_prev);
      fired2 = (bus2.imem_req_valid === 1'b1);
      addr2_prev = bus2.imem_req_addr;
      if (fired2) req_log2.push_back(bus2.imem_req_addr);
    end
  end

  // Ends on the negedge of the BOOT cycle (first cycle after reset release).
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_if_valid(input int budget);
    int n = 0;
    while (bus.if_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_if_valid_timeout", bus.if_valid, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_req;
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_req_valid", bus.imem_req_valid, 1'b0);
    check("rst_req_addr", bus.imem_req_addr, 32'h0);
    check("rst_if_valid", bus.if_valid, 1'b0);
    check("rst_if_instr", bus.if_instr, 32'h0);
    check("rst_if_pc", bus.if_pc, 32'h0);
    check("rst_if_fault", bus.if_fault, 1'b0);
    check("rst_dbg_count", dbg_count, 0);

    // 1: streaming at latency 1; BOOT idle cycle, first if_valid three cycles later.
    lat = 1;
    bus.if_ready = 1'b1;
    do_reset();
    check("t1_boot_no_req", bus.imem_req_valid, 1'b0);
    @(negedge clk);
    check("t1_first_req_valid", bus.imem_req_valid, 1'b1);
    check("t1_first_req_addr", bus.imem_req_addr, 32'h0);
    @(negedge clk);
    check("t1_c2_if_valid", bus.if_valid, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t1_if_valid", bus.if_valid, 1'b1);
      check("t1_if_pc", bus.if_pc, 32'(4 * k));
      check("t1_if_instr", bus.if_instr, instr_of(32'(4 * k)));
    end
    check("t1_req0", req_log[0], 32'h0);
    check("t1_req1", req_log[1], 32'h4);
    check("t1_req2", req_log[2], 32'h8);

    // 5: wrap-around instance streamed alongside test 1.
    check("t5_req0", req_log2[0], 32'hFFFF_FFF8);
    check("t5_req1", req_log2[1], 32'hFFFF_FFFC);
    check("t5_req2", req_log2[2], 32'h0000_0000);

    // 2: core stalled -> exactly DEPTH requests, then credit returns after one pop.
    bus.if_ready = 1'b0;
    do_reset();
    repeat (12) @(negedge clk);
    check("t2_req_count", req_log.size(), 4);
    check("t2_dbg_count", dbg_count, 4);
    check("t2_req_blocked", bus.imem_req_valid, 1'b0);
    check("t2_head_pc", bus.if_pc, 32'h0);
    bus.if_ready = 1'b1;
    @(negedge clk);
    bus.if_ready = 1'b0;
    check("t2_after_pop_pc", bus.if_pc, 32'h4);
    check("t2_after_pop_count", dbg_count, 3);
    check("t2_after_pop_req_valid", bus.imem_req_valid, 1'b1);
    check("t2_after_pop_req_addr", bus.imem_req_addr, 32'h10);

    // 3: redirect at latency 3 with three requests in flight (third handshaking now).
    lat = 3;
    bus.if_ready = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    check("t3_c3_req_addr", bus.imem_req_addr, 32'h8);
    check("t3_c3_req_valid", bus.imem_req_valid, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    check("t3_c4_req_addr", bus.imem_req_addr, 32'h100);
    for (int c = 4; c < 8; c++) begin
      check("t3_dropped_if_valid", bus.if_valid, 1'b0);
      @(negedge clk);
    end
    check("t3_c8_if_valid", bus.if_valid, 1'b1);
    check("t3_c8_if_pc", bus.if_pc, 32'h100);
    check("t3_c8_if_instr", bus.if_instr, instr_of(32'h100));

    // 4: redirect coinciding with a pop and an arriving response.
    lat = 1;
    do_reset();
    repeat (3) @(negedge clk);
    check("t4_c3_if_pc", bus.if_pc, 32'h0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    check("t4_c4_count", dbg_count, 0);
    check("t4_c4_if_valid", bus.if_valid, 1'b0);
    @(negedge clk);
    check("t4_c5_if_valid", bus.if_valid, 1'b0);
    @(negedge clk);
    check("t4_c6_if_valid", bus.if_valid, 1'b1);
    check("t4_c6_if_pc", bus.if_pc, 32'h40);

    // Reset asserted mid-stream: state returns to reset values immediately.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_count", dbg_count, 0);
    check("midrst_if_valid", bus.if_valid, 1'b0);
    check("midrst_req_valid", bus.imem_req_valid, 1'b0);
    check("midrst_req_addr", bus.imem_req_addr, 32'h0);

    // 6: misaligned redirect.
    do_reset();
    repeat (2) @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h102;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
`ifdef ALIGN_CHECK_EN
    check("t6_fault_set", bus.if_fault, 1'b1);
    check("t6_halt_no_req", bus.imem_req_valid, 1'b0);
    check("t6_halt_if_valid", bus.if_valid, 1'b0);
    n_req = req_log.size();
    repeat (5) @(negedge clk);
    check("t6_fault_held", bus.if_fault, 1'b1);
    check("t6_no_new_reqs", req_log.size(), n_req);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    check("t6_fault_clear", bus.if_fault, 1'b0);
    check("t6_resume_req_valid", bus.imem_req_valid, 1'b1);
    check("t6_resume_req_addr", bus.imem_req_addr, 32'h200);
    wait_if_valid(10);
    check("t6_resume_if_pc", bus.if_pc, 32'h200);
    check("t6_resume_if_instr", bus.if_instr, instr_of(32'h200));
`else
    n_req = 0;
    check("t6_no_fault", bus.if_fault, 1'b0);
    check("t6_masked_req_addr", bus.imem_req_addr, 32'h100);
    wait_if_valid(10);
    check("t6_masked_if_pc", bus.if_pc, 32'h100 + 32'(n_req));
    check("t6_masked_if_instr", bus.if_instr, instr_of(32'h100));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
